// File: rtl/vproc_unit_queue.sv
// In-order decoded-op queue in front of a unit pipeline: hazard/speculation-gated issue,
// silent discard of killed ops, and publication of the pending-read set of queued ops.
module vproc_unit_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned XIF_ID_W   = 3,
    parameter int unsigned XIF_ID_CNT = 8,
    parameter int unsigned PAYLOAD_W  = 64,
    parameter bit          ALLOW_SPEC = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         async_rst_ni,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  logic [XIF_ID_W-1:0]          enq_id_i,
    input  logic [31:0]                  enq_rd_set_i,
    input  logic [31:0]                  enq_wr_set_i,
    input  logic [PAYLOAD_W-1:0]         enq_payload_i,
    output logic                         op_rdy_o,
    input  logic                         op_ack_i,
    output logic [XIF_ID_W-1:0]          op_id_o,
    output logic [PAYLOAD_W-1:0]         op_payload_o,
    input  logic [31:0]                  vreg_pend_wr_i,
    input  logic [31:0]                  vreg_pend_rd_i,
    output logic [31:0]                  vreg_pend_rd_o,
    input  logic [XIF_ID_CNT-1:0]        instr_spec_i,
    input  logic [XIF_ID_CNT-1:0]        instr_killed_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]     valid_r;
    logic [DEPTH-1:0]     killed_r;
    logic [XIF_ID_W-1:0]  id_r      [DEPTH];
    logic [31:0]          rd_set_r  [DEPTH];
    logic [31:0]          wr_set_r  [DEPTH];
    logic [PAYLOAD_W-1:0] payload_r [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [CNT_W-1:0]     count_r;

    logic                 head_valid_s;
    logic [XIF_ID_W-1:0]  head_id_s;
    logic                 head_kill_s;
    logic                 haz_s;
    logic                 spec_blk_s;
    logic                 rdy_s;
    logic                 enq_s;
    logic                 deq_s;
    logic [31:0]          pend_rd_s;

    // Head evaluation: a killed head is discarded regardless of ack, otherwise issued on ack.
    always_comb begin
        head_valid_s = valid_r[rd_ptr_r];
        head_id_s    = id_r[rd_ptr_r];
        head_kill_s  = killed_r[rd_ptr_r] | instr_killed_i[head_id_s];
        haz_s        = (|(rd_set_r[rd_ptr_r] & vreg_pend_wr_i)) |
                       (|(wr_set_r[rd_ptr_r] & vreg_pend_wr_i)) |
                       (|(wr_set_r[rd_ptr_r] & vreg_pend_rd_i));
        spec_blk_s   = (ALLOW_SPEC == 1'b0) & instr_spec_i[head_id_s];
        rdy_s        = head_valid_s & ~head_kill_s & ~haz_s & ~spec_blk_s;
        enq_s        = enq_valid_i & (count_r < CNT_W'(DEPTH));
        deq_s        = head_valid_s & (head_kill_s | (rdy_s & op_ack_i));
    end

    // Pending-read set from stored state only; same-cycle kills/enqueues appear next cycle.
    always_comb begin
        pend_rd_s = 32'd0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (valid_r[e] && !killed_r[e]) begin
                pend_rd_s = pend_rd_s | rd_set_r[e];
            end else begin
                pend_rd_s = pend_rd_s;
            end
        end
    end

    // Output drive; head fields read as zero while the head slot is empty.
    always_comb begin
        op_rdy_o       = rdy_s;
        enq_ready_o    = (count_r < CNT_W'(DEPTH));
        count_o        = count_r;
        vreg_pend_rd_o = pend_rd_s;
        if (head_valid_s) begin
            op_id_o      = head_id_s;
            op_payload_o = payload_r[rd_ptr_r];
        end else begin
            op_id_o      = {XIF_ID_W{1'b0}};
            op_payload_o = {PAYLOAD_W{1'b0}};
        end
    end

    // Circular-buffer state: sticky kill capture, dequeue at rd_ptr, enqueue at wr_ptr.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            valid_r  <= {DEPTH{1'b0}};
            killed_r <= {DEPTH{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int unsigned e = 0; e < DEPTH; e++) begin
                id_r[e]      <= {XIF_ID_W{1'b0}};
                rd_set_r[e]  <= 32'd0;
                wr_set_r[e]  <= 32'd0;
                payload_r[e] <= {PAYLOAD_W{1'b0}};
            end
        end else begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (valid_r[e]) begin
                    killed_r[e] <= killed_r[e] | instr_killed_i[id_r[e]];
                end
            end
            // Full blocks enqueue and empty blocks dequeue, so both never hit the same slot.
            if (deq_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end
            if (enq_s) begin
                valid_r[wr_ptr_r]   <= 1'b1;
                killed_r[wr_ptr_r]  <= instr_killed_i[enq_id_i];
                id_r[wr_ptr_r]      <= enq_id_i;
                rd_set_r[wr_ptr_r]  <= enq_rd_set_i;
                wr_set_r[wr_ptr_r]  <= enq_wr_set_i;
                payload_r[wr_ptr_r] <= enq_payload_i;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
